// File: rtl/store_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : store_writer                                                 |
// | Description : Accepts LSU store requests, formats them into word-aligned   |
// |               write beats with byte enables, queues them in a small FIFO   |
// |               and drains them to the data-memory write port over a         |
// |               valid/ready handshake. Misaligned stores are dropped and     |
// |               flagged with a one-cycle error pulse.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module store_writer #(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  // LSU side
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  // Data-memory write port
  output logic        mem_wvalid,
  input  logic        mem_wready,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  // Status
  output logic        err_misalign,
  output logic        idle
);

  // Index width; pointers carry one extra wrap bit to tell full from empty.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  logic [31:0] addr_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [3:0]  mask_q [DEPTH];

  logic        full;
  logic        empty;
  logic        accept;
  logic        push;
  logic        pop;

  logic [1:0]  off;
  logic        misalign;
  logic [31:0] fmt_addr;
  logic [31:0] fmt_data;
  logic [3:0]  fmt_mask;

  logic        err_q;

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
  assign empty = (wr_ptr == rd_ptr);

  // Ready is a pure function of FIFO state; a full FIFO is never bypassed.
  assign req_ready = !full;
  assign accept    = req_valid && !full;
  // Rejected requests are consumed by the handshake but never stored.
  assign push      = accept && !misalign;
  assign pop       = !empty && mem_wready;

  assign off      = req_addr[1:0];
  assign fmt_addr = {req_addr[31:2], 2'b00};

  // Lane formatting and alignment check, done at accept time.
  always_comb begin
    misalign = 1'b0;
    fmt_data = req_data;
    fmt_mask = 4'b0000;
    case (req_size)
      SIZE_BYTE: begin
        fmt_mask = 4'b0001 << off;
        fmt_data = {4{req_data[7:0]}};
      end
      SIZE_HALF: begin
        if (off[0]) begin
          misalign = 1'b1;
        end else begin
          fmt_mask = 4'b0011 << off;
          fmt_data = {2{req_data[15:0]}};
        end
      end
      SIZE_WORD: begin
        if (off != 2'b00) begin
          misalign = 1'b1;
        end else begin
          fmt_mask = 4'b1111;
          fmt_data = req_data;
        end
      end
      default: begin
        misalign = 1'b1;
      end
    endcase
  end

  // Pointer update; push and pop may occur together, keeping occupancy flat.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (AW + 1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW + 1)'(1);
      end
    end
  end

  // Entry storage; contents are only observed through the empty-gated outputs.
  always_ff @(posedge clock) begin
    if (push) begin
      addr_q[wr_idx] <= fmt_addr;
      data_q[wr_idx] <= fmt_data;
      mask_q[wr_idx] <= fmt_mask;
    end
  end

  // Error pulse lands in the cycle after the rejecting handshake.
  always_ff @(posedge clock) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept && misalign;
    end
  end

  // Head entry drives the write port; all fields read zero while empty.
  always_comb begin
    mem_wvalid = !empty;
    mem_waddr  = '0;
    mem_wdata  = '0;
    mem_wmask  = '0;
    if (!empty) begin
      mem_waddr = addr_q[rd_idx];
      mem_wdata = data_q[rd_idx];
      mem_wmask = mask_q[rd_idx];
    end
  end

  assign err_misalign = err_q;
  assign idle         = empty;

endmodule
`default_nettype wire

// File: tb/tb_store_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_store_writer                                              |
// | Description : Directed, scoreboard-checked bench for store_writer.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_store_writer;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } beat_t;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        err_misalign;
  logic        idle;

  beat_t sb[$];
  int    checks     = 0;
  int    errors     = 0;
  int    err_expect = 0;
  int    beats_seen = 0;

  store_writer #(.DEPTH(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_size     (req_size),
    .mem_wvalid   (mem_wvalid),
    .mem_wready   (mem_wready),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .err_misalign (err_misalign),
    .idle         (idle)
  );

  // 10 ns clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every write handshake and matches error pulses.
  always @(negedge clock) begin
    if (reset === 1'b1 && mem_wvalid === 1'b1 && mem_wready === 1'b1) begin
      beats_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got addr 0x%08h with empty scoreboard", mem_waddr);
      end else begin
        beat_t e;
        e = sb.pop_front();
        chk("beat_addr", mem_waddr, e.a);
        chk("beat_data", mem_wdata, e.d);
        chk("beat_mask", {28'd0, mem_wmask}, {28'd0, e.m});
      end
    end
    if (reset === 1'b1 && err_misalign === 1'b1) begin
      checks++;
      if (err_expect > 0) begin
        err_expect--;
      end else begin
        errors++;
        $display("FAIL unexpected_err_pulse: got 1 expected 0");
      end
    end
  end

  // Caller must be positioned just after a rising edge.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                      input bit is_err, input logic [31:0] ea, input logic [31:0] ed,
                      input logic [3:0] em);
    int budget;
    budget    = 0;
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_size  = s;
    @(negedge clock);
    while (req_ready !== 1'b1 && budget < 50) begin
      @(negedge clock);
      budget++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got req_ready %b expected 1", req_ready);
    end else begin
      @(posedge clock);
      if (is_err) err_expect++;
      else sb.push_back('{a: ea, d: ed, m: em});
    end
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    @(negedge clock);
    while (idle !== 1'b1 && budget < 50) begin
      @(negedge clock);
      budget++;
    end
    chk("wait_idle", {31'd0, idle}, 32'd1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int snap;
    reset      = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 32'h8000_0000;
    req_data   = 32'h5555_5555;
    req_size   = 2'd2;
    mem_wready = 1'b1;

    // Reset held two cycles with a pending request: nothing must be enqueued.
    repeat (2) @(posedge clock);
    #1;
    reset     = 1'b1;
    req_valid = 1'b0;
    @(negedge clock);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_wvalid", {31'd0, mem_wvalid}, 32'd0);
    chk("rst_idle", {31'd0, idle}, 32'd1);
    chk("rst_err", {31'd0, err_misalign}, 32'd0);
    chk("rst_waddr", mem_waddr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_wmask", {28'd0, mem_wmask}, 32'd0);
    @(posedge clock);
    #1;

    // Byte store into lane 3, with one-cycle latency check.
    send(32'h8000_0003, 32'h0000_00AB, 2'd0, 1'b0, 32'h8000_0000, 32'hABAB_ABAB, 4'b1000);
    @(negedge clock);
    chk("byte_latency_wvalid", {31'd0, mem_wvalid}, 32'd1);
    @(posedge clock);
    #1;
    wait_idle();

    // Half into upper lanes, then an aligned word.
    send(32'h8000_0006, 32'h0000_1234, 2'd1, 1'b0, 32'h8000_0004, 32'h1234_1234, 4'b1100);
    send(32'h8000_0008, 32'hDEAD_BEEF, 2'd2, 1'b0, 32'h8000_0008, 32'hDEAD_BEEF, 4'b1111);
    send(32'h8000_000D, 32'hFFFF_FF5A, 2'd0, 1'b0, 32'h8000_000C, 32'h5A5A_5A5A, 4'b0010);
    wait_idle();

    // Misaligned requests: each pulses the error once and never reaches memory.
    send(32'h8000_0001, 32'h0000_BEEF, 2'd1, 1'b1, 32'd0, 32'd0, 4'd0);
    @(negedge clock);
    chk("mis_half_err", {31'd0, err_misalign}, 32'd1);
    chk("mis_half_wvalid", {31'd0, mem_wvalid}, 32'd0);
    @(posedge clock);
    #1;
    send(32'h8000_0002, 32'h1111_2222, 2'd2, 1'b1, 32'd0, 32'd0, 4'd0);
    @(negedge clock);
    chk("mis_word_err", {31'd0, err_misalign}, 32'd1);
    chk("mis_word_wvalid", {31'd0, mem_wvalid}, 32'd0);
    @(posedge clock);
    #1;
    send(32'h8000_0000, 32'h3333_4444, 2'd3, 1'b1, 32'd0, 32'd0, 4'd0);
    @(negedge clock);
    chk("mis_size3_err", {31'd0, err_misalign}, 32'd1);
    chk("mis_size3_wvalid", {31'd0, mem_wvalid}, 32'd0);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("mis_err_drop", {31'd0, err_misalign}, 32'd0);
    chk("mis_idle", {31'd0, idle}, 32'd1);
    @(posedge clock);
    #1;

    // Back-pressure: A and B fill the FIFO, C is held off.
    mem_wready = 1'b0;
    send(32'h0000_0100, 32'hAAAA_0001, 2'd2, 1'b0, 32'h0000_0100, 32'hAAAA_0001, 4'b1111);
    send(32'h0000_0104, 32'hBBBB_0002, 2'd2, 1'b0, 32'h0000_0104, 32'hBBBB_0002, 4'b1111);
    req_valid = 1'b1;
    req_addr  = 32'h0000_0108;
    req_data  = 32'hCCCC_0003;
    req_size  = 2'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("full_req_ready", {31'd0, req_ready}, 32'd0);
      chk("hold_waddr", mem_waddr, 32'h0000_0100);
      chk("hold_wdata", mem_wdata, 32'hAAAA_0001);
      chk("hold_wmask", {28'd0, mem_wmask}, 32'h0000_000F);
      @(posedge clock);
      #1;
    end
    mem_wready = 1'b1;
    @(negedge clock);
    chk("full_pop_cycle_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("after_pop_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clock);
    sb.push_back('{a: 32'h0000_0108, d: 32'hCCCC_0003, m: 4'b1111});
    #1;
    req_valid = 1'b0;
    wait_idle();

    // Streaming: ten back-to-back words, one beat per cycle through pointer wrap.
    snap = beats_seen;
    for (int i = 0; i < 10; i++) begin
      send(32'h0000_1000 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 2'd2, 1'b0,
           32'h0000_1000 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 4'b1111);
    end
    @(negedge clock);
    #1;
    chk("stream_beats", 32'(beats_seen - snap), 32'd10);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("stream_idle", {31'd0, idle}, 32'd1);
    chk("stream_wvalid_low", {31'd0, mem_wvalid}, 32'd0);

    // Everything issued must have been observed.
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("err_pulses_seen", 32'(err_expect), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
